rect_fill_writer: RTL and testbench

Rectangle fill engine that sits directly upstream of the frame buffer's write port. It accepts one rectangle command at a time (origin, size, 24-bit colour) over a valid/ready handshake. It clips the rectangle to the visible area and streams one pixel write per clock as a linear address and data pair on WRITE_ADDR/WRITE_DATA. The game logic uses it to paint paddles, ball and background into the buffer.

---
 rtl/rect_fill_writer.sv | 205 ++++++++++++++++++++
 tb/tb_rect_fill_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: clips one command to the visible area and streams
// one linear-address pixel write per clock into the frame buffer write port.
module rect_fill_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 24
) (
  input  logic               WRITE_CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [9:0]         CMD_X,
  input  logic [8:0]         CMD_Y,
  input  logic [9:0]         CMD_W,
  input  logic [8:0]         CMD_H,
  input  logic [COLOR_W-1:0] CMD_COLOR,
  output logic               WRITE_EN,
  output logic [ADDR_W-1:0]  WRITE_ADDR,
  output logic [COLOR_W-1:0] WRITE_DATA,
  output logic               BUSY,
  output logic               DONE
);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_FIN} state_t;

  localparam logic [10:0]       H_LIM  = 11'(H_RES);
  localparam logic [9:0]        V_LIM  = 10'(V_RES);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  // Row start address as a sum of shifted copies of y, one per set bit of H_RES.
  function automatic logic [ADDR_W-1:0] row_of(input logic [8:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < 31; k++) begin
      if (H_RES[k]) acc = acc + (ADDR_W'(y) << k);
    end
    return acc;
  endfunction

  state_t               state_q, state_d;
  logic [9:0]           x_q, x_d;
  logic [8:0]           y_q, y_d;
  logic [9:0]           w_q, w_d;
  logic [8:0]           h_q, h_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [10:0]          x_end_q, x_end_d;
  logic [9:0]           y_end_q, y_end_d;
  logic [9:0]           cx_q, cx_d;
  logic [8:0]           cy_q, cy_d;
  logic [ADDR_W-1:0]    row_base_q, row_base_d;
  logic                 ready_q, ready_d;
  logic                 en_q, en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [10:0]          x_sum_c, x_end_c;
  logic [9:0]           y_sum_c, y_end_c;
  logic                 empty_c;
  logic [ADDR_W-1:0]    row_c;
  logic                 x_last_c, y_last_c;

  // Clip arithmetic is one bit wider than the coordinates so the sums never wrap.
  always_comb begin
    x_sum_c  = {1'b0, x_q} + {1'b0, w_q};
    y_sum_c  = {1'b0, y_q} + {1'b0, h_q};
    x_end_c  = (x_sum_c > H_LIM) ? H_LIM : x_sum_c;
    y_end_c  = (y_sum_c > V_LIM) ? V_LIM : y_sum_c;
    empty_c  = (w_q == 10'd0) || (h_q == 9'd0) ||
               ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
    row_c    = row_of(y_q);
    x_last_c = ({1'b0, cx_q} == (x_end_q - 11'd1));
    y_last_c = ({1'b0, cy_q} == (y_end_q - 10'd1));
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    en_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (CMD_VALID && ready_q) begin
          x_d     = CMD_X;
          y_d     = CMD_Y;
          w_d     = CMD_W;
          h_d     = CMD_H;
          color_d = CMD_COLOR;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CLIP;
        end
      end

      S_CLIP: begin
        x_end_d = x_end_c;
        y_end_d = y_end_c;
        if (empty_c) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          // The first pixel is presented on the same edge that enters FILL.
          cx_d       = x_q;
          cy_d       = y_q;
          row_base_d = row_c;
          addr_d     = row_c + ADDR_W'(x_q);
          data_d     = color_q;
          en_d       = 1'b1;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        if (x_last_c && y_last_c) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else if (x_last_c) begin
          en_d       = 1'b1;
          cx_d       = x_q;
          cy_d       = cy_q + 9'd1;
          row_base_d = row_base_q + STRIDE;
          addr_d     = row_base_q + STRIDE + ADDR_W'(x_q);
        end else begin
          en_d   = 1'b1;
          cx_d   = cx_q + 10'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_FIN: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge WRITE_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign CMD_READY  = ready_q;
  assign WRITE_EN   = en_q;
  assign WRITE_ADDR = addr_q;
  assign WRITE_DATA = data_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer: directed and random rectangles checked against
// a row/column loop model of the clipped fill; a small-screen instance covers a full fill.
module tb_rect_fill_writer;

  logic        clk;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [9:0]  CMD_X;
  logic [8:0]  CMD_Y;
  logic [9:0]  CMD_W;
  logic [8:0]  CMD_H;
  logic [23:0] CMD_COLOR;
  logic        WRITE_EN;
  logic [18:0] WRITE_ADDR;
  logic [23:0] WRITE_DATA;
  logic        BUSY;
  logic        DONE;

  logic        s_valid, s_ready, s_en, s_busy, s_done;
  logic [9:0]  s_x, s_w;
  logic [8:0]  s_y, s_h;
  logic [23:0] s_color, s_data;
  logic [10:0] s_addr;

  int n_cmp = 0;
  int n_bad = 0;

  rect_fill_writer #(.H_RES(640), .V_RES(480), .ADDR_W(19), .COLOR_W(24)) dut (
    .WRITE_CLK(clk), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_W(CMD_W), .CMD_H(CMD_H), .CMD_COLOR(CMD_COLOR),
    .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  rect_fill_writer #(.H_RES(40), .V_RES(30), .ADDR_W(11), .COLOR_W(24)) dut_small (
    .WRITE_CLK(clk), .RESET(RESET), .CMD_VALID(s_valid), .CMD_READY(s_ready),
    .CMD_X(s_x), .CMD_Y(s_y), .CMD_W(s_w), .CMD_H(s_h), .CMD_COLOR(s_color),
    .WRITE_EN(s_en), .WRITE_ADDR(s_addr), .WRITE_DATA(s_data),
    .BUSY(s_busy), .DONE(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string nm);
    int t = 0;
    while (CMD_READY !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (CMD_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_wait: got %b want 1", nm, CMD_READY);
    end
  endtask

  // Drives one command and checks the full response against the fill model.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [23:0] col, input string nm);
    int exp_a[$];
    int got_a[$];
    int t, done_t, busy_n, bad_data, n;
    bit done_seen;
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++)
        if (r < 480 && c < 640) exp_a.push_back(r * 640 + c);
    n = exp_a.size();

    wait_ready(nm);
    CMD_X = 10'(x); CMD_Y = 9'(y); CMD_W = 10'(w); CMD_H = 9'(h); CMD_COLOR = col;
    CMD_VALID = 1'b1;
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    n_cmp++;
    if (CMD_READY !== 1'b0 || BUSY !== 1'b1 || WRITE_EN !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: ready=%b busy=%b en=%b want 0 1 0", nm, CMD_READY, BUSY, WRITE_EN);
    end

    busy_n = 1; bad_data = 0; done_seen = 0; done_t = -1; t = 0;
    while (!done_seen && t < n + 8) begin
      @(posedge clk); #1; t++;
      if (BUSY === 1'b1) busy_n++;
      if (WRITE_EN === 1'b1) begin
        got_a.push_back(int'(WRITE_ADDR));
        if (WRITE_DATA !== col) bad_data++;
      end
      if (DONE === 1'b1) begin
        done_seen = 1; done_t = t;
      end
    end

    n_cmp++;
    if (done_t != n + 1) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", nm, done_t, n + 1);
    end
    n_cmp++;
    if (got_a.size() != n) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d want %0d", nm, got_a.size(), n);
    end
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] != exp_a[i]) begin
        n_bad++;
        $display("FAIL %s addr[%0d]: got %0d want %0d", nm, i, got_a[i], exp_a[i]);
      end
    end
    n_cmp++;
    if (bad_data != 0) begin
      n_bad++;
      $display("FAIL %s data: %0d writes differ from colour %06h", nm, bad_data, col);
    end
    // BUSY covers CLIP, every write and the DONE cycle.
    n_cmp++;
    if (busy_n != n + 2) begin
      n_bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, n + 2);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_done: ready=%b busy=%b done=%b want 1 0 0", nm, CMD_READY, BUSY, DONE);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (CMD_READY !== 1'b0 || WRITE_EN !== 1'b0 || WRITE_ADDR !== 19'd0 ||
        WRITE_DATA !== 24'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: ready=%b en=%b addr=%0d data=%06h busy=%b done=%b want all 0",
               CMD_READY, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY, DONE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (CMD_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 0", CMD_READY);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (CMD_READY !== 1'b1 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_edge_ready: got %b/%b want 1/1", CMD_READY, s_ready);
    end
  endtask

  task automatic test_basic();
    run_cmd(10, 2, 3, 2, 24'hFF00FF, "basic");
  endtask

  task automatic test_clip();
    run_cmd(638, 479, 5, 4, 24'h123456, "clip_br");
    run_cmd(600, 100, 200, 2, 24'hABCDEF, "clip_right");
  endtask

  task automatic test_empty();
    run_cmd(5, 5, 0, 3, 24'h00FF00, "empty_w0");
    run_cmd(700, 5, 4, 3, 24'h0000FF, "empty_x700");
    run_cmd(5, 480, 4, 3, 24'h0000FF, "empty_y480");
  endtask

  task automatic test_back_to_back();
    logic en_t[1:8], done_t[1:8], rdy_t[1:8];
    int   addr_t[1:8];
    logic [23:0] data_t[1:8];
    logic exp_en[1:8], exp_done[1:8], exp_rdy[1:8];
    exp_en   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_ready("b2b");
    CMD_X = 10'd0; CMD_Y = 9'd0; CMD_W = 10'd1; CMD_H = 9'd1; CMD_COLOR = 24'h111111;
    CMD_VALID = 1'b1;
    @(posedge clk); #1;
    CMD_X = 10'd639; CMD_Y = 9'd479; CMD_COLOR = 24'h222222;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      en_t[t] = WRITE_EN; done_t[t] = DONE; rdy_t[t] = CMD_READY;
      addr_t[t] = int'(WRITE_ADDR); data_t[t] = WRITE_DATA;
      if (t == 4) CMD_VALID = 1'b0;
    end
    for (int t = 1; t <= 8; t++) begin
      n_cmp++;
      if (en_t[t] !== exp_en[t] || done_t[t] !== exp_done[t] || rdy_t[t] !== exp_rdy[t]) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: en/done/ready=%b%b%b want %b%b%b", t,
                 en_t[t], done_t[t], rdy_t[t], exp_en[t], exp_done[t], exp_rdy[t]);
      end
    end
    n_cmp++;
    if (addr_t[1] != 0 || data_t[1] !== 24'h111111) begin
      n_bad++;
      $display("FAIL b2b_write1: addr=%0d data=%06h want 0 111111", addr_t[1], data_t[1]);
    end
    n_cmp++;
    if (addr_t[5] != 307199 || data_t[5] !== 24'h222222) begin
      n_bad++;
      $display("FAIL b2b_write2: addr=%0d data=%06h want 307199 222222", addr_t[5], data_t[5]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      int x, y, w, h;
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 500));
      w = int'($urandom_range(0, 48));
      h = int'($urandom_range(0, 12));
      if (i % 4 == 0) begin
        x = 640 - int'($urandom_range(1, 20));
        y = 480 - int'($urandom_range(1, 6));
      end
      run_cmd(x, y, w, h, 24'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_fill();
    int wr = 0;
    int t = 0;
    bit done_seen = 0;
    wait_ready("rst_mid");
    CMD_X = 10'd0; CMD_Y = 9'd0; CMD_W = 10'd640; CMD_H = 9'd480; CMD_COLOR = 24'h0F0F0F;
    CMD_VALID = 1'b1;
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    while (wr < 100 && t < 200) begin
      @(posedge clk); #1; t++;
      if (WRITE_EN === 1'b1) wr++;
      if (DONE === 1'b1) done_seen = 1;
    end
    n_cmp++;
    if (wr != 100 || WRITE_EN !== 1'b1 || WRITE_ADDR !== 19'd99) begin
      n_bad++;
      $display("FAIL rst_mid_prefill: writes=%0d en=%b addr=%0d want 100 1 99", wr, WRITE_EN, WRITE_ADDR);
    end
    #1 RESET = 1'b1;
    #1;
    n_cmp++;
    if (WRITE_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b0 ||
        WRITE_ADDR !== 19'd0 || WRITE_DATA !== 24'd0) begin
      n_bad++;
      $display("FAIL rst_mid_async_clear: en=%b done=%b busy=%b ready=%b addr=%0d data=%06h want all 0",
               WRITE_EN, DONE, BUSY, CMD_READY, WRITE_ADDR, WRITE_DATA);
    end
    repeat (2) @(posedge clk);
    #3 RESET = 1'b0;
    #1;
    n_cmp++;
    if (CMD_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_release_ready: got %b want 0", CMD_READY);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || WRITE_EN !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after_edge: ready=%b busy=%b en=%b want 1 0 0", CMD_READY, BUSY, WRITE_EN);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (DONE === 1'b1 || WRITE_EN === 1'b1) done_seen = 1;
    end
    n_cmp++;
    if (done_seen) begin
      n_bad++;
      $display("FAIL rst_mid_no_done: got activity=1 want 0");
    end
  endtask

  // Whole-screen fill on a 40x30 instance, oversized command clipped to the screen.
  task automatic test_full_screen_small();
    int n = 0;
    int t = 0;
    int done_t = -1;
    int bad_data = 0;
    while (s_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    s_x = 10'd0; s_y = 9'd0; s_w = 10'd1023; s_h = 9'd511; s_color = 24'hC0FFEE;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    t = 0;
    while (done_t < 0 && t < 1300) begin
      @(posedge clk); #1; t++;
      if (s_en === 1'b1) begin
        n_cmp++;
        if (int'(s_addr) != n) begin
          n_bad++;
          $display("FAIL full_addr[%0d]: got %0d want %0d", n, s_addr, n);
        end
        if (s_data !== 24'hC0FFEE) bad_data++;
        n++;
      end
      if (s_done === 1'b1) done_t = t;
    end
    n_cmp++;
    if (n != 1200 || done_t != 1201) begin
      n_bad++;
      $display("FAIL full_count: writes=%0d done_cycle=%0d want 1200 1201", n, done_t);
    end
    n_cmp++;
    if (bad_data != 0) begin
      n_bad++;
      $display("FAIL full_data: %0d writes differ from C0FFEE", bad_data);
    end
  endtask

  initial begin
    CMD_VALID = 1'b0; CMD_X = '0; CMD_Y = '0; CMD_W = '0; CMD_H = '0; CMD_COLOR = '0;
    s_valid = 1'b0; s_x = '0; s_y = '0; s_w = '0; s_h = '0; s_color = '0;
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    test_full_screen_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
